// File: rtl/fixed_div_arb_pkg.sv
// fixed_div_pkg: shared types and helpers for fixed_div_arb and the other
// shared-resource arbiters.
//   tag_t   - per-divide sideband carried alongside the divider pipeline
//   pick_t  - result of a round-robin search
//   idx_w   - index width for an N-way requester set (at least 1 bit)
//   rr_pick - round-robin search starting at ptr, wrapping modulo n
// Requester counts up to NREQ_MAX are supported.
package fixed_div_pkg;

   localparam int NREQ_MAX  = 32;
   localparam int IDX_MAX_W = 5;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                 v;
      logic [IDX_MAX_W-1:0] idx;
      logic                 dbz;
   } tag_t;

   typedef struct packed {
      logic                 found;
      logic [IDX_MAX_W-1:0] idx;
   } pick_t;

   // The loop runs from farthest to nearest distance, so the last hit to be
   // written is the one closest to ptr.
   function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                     input int n, input int ptr);
      pick_t p;
      int    j;
      p = '0;
      for (int k = NREQ_MAX - 1; k >= 0; k--) begin
         if (k < n) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (valid[j[IDX_MAX_W-1:0]]) begin
               p.found = 1'b1;
               p.idx   = j[IDX_MAX_W-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/fixed_div_arb_if.sv
// fixed_div_arb_if: requester-side bus of the shared divider arbiter.
//   req_valid/req_ready        - per-requester valid/ready, ready is one-hot
//   req_dividend/req_divisor   - packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid                  - one-cycle pulse to the originating requester
//   rsp_quotient/rsp_dbz       - result and zero-divisor flag
// master = requesters, slave = arbiter.
interface fixed_div_arb_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int STEPS = 8
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_dividend;
   logic [NREQ*WIDTH-1:0] req_divisor;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [STEPS-1:0]      rsp_quotient;
   logic                  rsp_dbz;

   modport master (output req_valid, req_dividend, req_divisor,
                   input  req_ready, rsp_valid, rsp_quotient, rsp_dbz);
   modport slave  (input  req_valid, req_dividend, req_divisor,
                   output req_ready, rsp_valid, rsp_quotient, rsp_dbz);
endinterface

// File: rtl/fixed_div_arb_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a combinational pick and a
// registered pointer.
//   clk, nrst  - clock, asynchronous active-low reset (pointer -> 0)
//   en         - grant enable
//   valid      - request vector
//   ready      - one-hot grant (0 when disabled or idle)
//   grant      - granted index, meaningful when found = 1
//   found      - a grant is being made this cycle
// The pointer moves to one past the winner after each grant and holds
// otherwise.
module rr_arbiter
   import fixed_div_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          en,
   input  logic [N-1:0]  valid,
   output logic [N-1:0]  ready,
   output logic [IW-1:0] grant,
   output logic          found
);
   logic [IW-1:0]       ptr;
   logic [NREQ_MAX-1:0] valid_ext;
   pick_t               pick;
   logic                unused_pick;

   always_comb begin
      valid_ext        = '0;
      valid_ext[N-1:0] = valid;
      pick             = rr_pick(valid_ext, N, int'(ptr));
      grant            = pick.idx[IW-1:0];
      found            = pick.found & en;
      ready            = found ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
   end

   assign unused_pick = ^pick.idx;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         ptr <= '0;
      else if (found)
         ptr <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
   end
endmodule

// File: rtl/fixed_div_arb.sv
// fixed_div_arb: shares one pipelined divider (fixed latency STEPS, no tag,
// no backpressure) among NREQ requesters.
//   clk, nrst       - clock, asynchronous active-low reset
//   en              - issue enable; in-flight results drain regardless
//   bus             - requester valid/ready, operands and responses
//   div_dividend, div_divisor, div_din_valid - issue side of the divider
//   div_quotient, div_dout_valid             - result side of the divider
//   inflight        - divides currently in the divider
//   err             - sticky: [0] tag vs divider valid mismatch,
//                             [1] operand with MSB set was issued
// A tag {v, idx, dbz} travels in a STEPS-deep shift register beside the
// divider, so each quotient arrives with the index of its requester. Zero
// divisors are still issued, and their result is replaced with all-ones.
module fixed_div_arb
   import fixed_div_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 8,
   parameter  int STEPS = 8,
   localparam int IW    = idx_w(NREQ),
   localparam int CW    = $clog2(STEPS + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   fixed_div_arb_if.slave   bus,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   output logic             div_din_valid,
   input  logic [STEPS-1:0] div_quotient,
   input  logic             div_dout_valid,
   output logic [CW-1:0]    inflight,
   output logic [1:0]       err
);
   logic [IW-1:0] grant;
   logic          found;
   tag_t          pipe [STEPS];
   tag_t          tag_in, tag_out;
   logic          unused_idx;

   // Gating with nrst keeps req_ready low while reset is held.
   rr_arbiter #(.N(NREQ)) u_arb (
      .clk   (clk),
      .nrst  (nrst),
      .en    (en & nrst),
      .valid (bus.req_valid),
      .ready (bus.req_ready),
      .grant (grant),
      .found (found)
   );

   always_comb begin
      div_din_valid = found;
      div_dividend  = '0;
      div_divisor   = '0;
      if (found) begin
         div_dividend = bus.req_dividend[int'(grant)*WIDTH +: WIDTH];
         div_divisor  = bus.req_divisor[int'(grant)*WIDTH +: WIDTH];
      end
      tag_in.v   = found;
      tag_in.idx = IDX_MAX_W'(grant);
      tag_in.dbz = found & (div_divisor == '0);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < STEPS; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < STEPS; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tag_out    = pipe[STEPS-1];
   assign unused_idx = ^tag_out.idx;

   // The response is driven only by the tag, so a stray or missing divider
   // valid never produces or drops a response. It only raises err[0].
   always_comb begin
      bus.rsp_valid    = '0;
      bus.rsp_quotient = '0;
      bus.rsp_dbz      = 1'b0;
      if (tag_out.v) begin
         bus.rsp_valid[tag_out.idx[IW-1:0]] = 1'b1;
         bus.rsp_quotient = tag_out.dbz ? '1 : div_quotient;
         bus.rsp_dbz      = tag_out.dbz;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         err      <= '0;
         inflight <= '0;
      end else begin
         if (tag_out.v != div_dout_valid) err[0] <= 1'b1;
         if (found && (div_dividend[WIDTH-1] || div_divisor[WIDTH-1])) err[1] <= 1'b1;
         case ({found, tag_out.v})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end
endmodule

// File: tb/tb_fixed_div_arb.sv
// Bench for fixed_div_arb. It contains a divider model with latency STEPS
// and quotient floor(a*2^(STEPS-1)/b), and it can inject a stray
// dout_valid. It drives a table of single-request vectors, followed by
// sequences covering continuous round-robin, en gating, mid-flight reset
// and the error flags.
module tb_fixed_div_arb;
   localparam int NREQ = 4, WIDTH = 8, STEPS = 8;

   logic clk = 1'b0;
   logic nrst, en, inject;
   logic [WIDTH-1:0] div_dividend, div_divisor;
   logic             div_din_valid, div_dout_valid;
   logic [STEPS-1:0] div_quotient;
   logic [3:0]       inflight;
   logic [1:0]       err;
   int checks = 0, errors = 0;

   fixed_div_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .STEPS(STEPS)) bus ();

   fixed_div_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .STEPS(STEPS)) dut (
      .clk            (clk),
      .nrst           (nrst),
      .en             (en),
      .bus            (bus.slave),
      .div_dividend   (div_dividend),
      .div_divisor    (div_divisor),
      .div_din_valid  (div_din_valid),
      .div_quotient   (div_quotient),
      .div_dout_valid (div_dout_valid),
      .inflight       (inflight),
      .err            (err)
   );

   always #5 clk = ~clk;

   // divider model
   logic [STEPS-1:0] mv;
   logic [STEPS-1:0] mq [STEPS];

   function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
      if (b == 0) return 8'h00;
      return 8'((int'(a) << 7) / int'(b));
   endfunction

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mv <= '0;
         for (int i = 0; i < STEPS; i++) mq[i] <= '0;
      end else begin
         mv    <= {mv[STEPS-2:0], div_din_valid};
         mq[0] <= ref_q(div_dividend, div_divisor);
         for (int i = 1; i < STEPS; i++) mq[i] <= mq[i-1];
      end
   end

   assign div_quotient   = mq[STEPS-1];
   assign div_dout_valid = mv[STEPS-1] | inject;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] dd, input logic [7:0] dv);
      bus.req_dividend[i*WIDTH +: WIDTH] = dd;
      bus.req_divisor[i*WIDTH +: WIDTH]  = dv;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      step();
      step();
      nrst = 1'b1;
   endtask

   typedef struct {
      int         r;
      logic [7:0] dd, dv, q;
      logic       dbz;
   } vec_t;
   vec_t vec [8];

   int grant_tab [12];
   int g, iss, rsp;
   logic early, hold_bad;

   initial begin
      vec[0] = '{2, 8'd3,   8'd4,  8'h60, 1'b0};
      vec[1] = '{0, 8'd1,   8'd2,  8'h40, 1'b0};
      vec[2] = '{1, 8'd5,   8'd0,  8'hFF, 1'b1};
      vec[3] = '{3, 8'd7,   8'd8,  8'h70, 1'b0};
      vec[4] = '{0, 8'd63,  8'd64, 8'h7E, 1'b0};
      vec[5] = '{2, 8'd10,  8'd7,  8'hB6, 1'b0};
      vec[6] = '{3, 8'd0,   8'd5,  8'h00, 1'b0};
      vec[7] = '{1, 8'd100, 8'd99, 8'h81, 1'b0};
      grant_tab = '{0, 1, 2, 3, 0, 1, -1, -1, -1, 2, 3, -1};

      nrst = 1'b0; en = 1'b1; inject = 1'b0;
      bus.req_valid = '0; bus.req_dividend = '0; bus.req_divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_q", bus.rsp_quotient, 0);
      check("rst_rsp_dbz", bus.rsp_dbz, 0);
      check("rst_din_valid", div_din_valid, 0);
      check("rst_inflight", inflight, 0);
      check("rst_err", err, 0);
      nrst = 1'b1;
      step();

      // single-request vectors
      for (int v = 0; v < 8; v++) begin
         set_req(vec[v].r, vec[v].dd, vec[v].dv);
         bus.req_valid = 4'(1 << vec[v].r);
         #1;
         check($sformatf("v%0d_ready", v), bus.req_ready, 1 << vec[v].r);
         check($sformatf("v%0d_div_in", v), {div_dividend, div_divisor}, {vec[v].dd, vec[v].dv});
         step();
         bus.req_valid = '0;
         early = 1'b0; hold_bad = 1'b0;
         repeat (7) begin
            if (bus.rsp_valid != 0) early = 1'b1;
            if (inflight != 1) hold_bad = 1'b1;
            step();
         end
         if (inflight != 1) hold_bad = 1'b1;
         check($sformatf("v%0d_no_early_rsp", v), early, 0);
         check($sformatf("v%0d_inflight_hold", v), hold_bad, 0);
         check($sformatf("v%0d_rsp_valid", v), bus.rsp_valid, 1 << vec[v].r);
         check($sformatf("v%0d_rsp_q", v), bus.rsp_quotient, vec[v].q);
         check($sformatf("v%0d_rsp_dbz", v), bus.rsp_dbz, vec[v].dbz);
         check($sformatf("v%0d_err", v), err, 0);
         step();
         check($sformatf("v%0d_inflight_end", v), inflight, 0);
      end

      // all requesters valid for 12 cycles, then drain
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd8);
      for (int c = 0; c < 20; c++) begin
         bus.req_valid = (c < 12) ? 4'hF : 4'h0;
         #1;
         check($sformatf("rr_c%0d_ready", c), bus.req_ready, (c < 12) ? (1 << (c % 4)) : 0);
         iss = (c < 12) ? c : 12;
         rsp = (c < 8) ? 0 : ((c - 8 < 12) ? c - 8 : 12);
         check($sformatf("rr_c%0d_inflight", c), inflight, iss - rsp);
         if (c >= 8) begin
            check($sformatf("rr_c%0d_rsp_valid", c), bus.rsp_valid, 1 << ((c - 8) % 4));
            check($sformatf("rr_c%0d_rsp_q", c), bus.rsp_quotient, (((c - 8) % 4) + 1) * 16);
         end else
            check($sformatf("rr_c%0d_rsp_valid", c), bus.rsp_valid, 0);
         step();
      end

      // en low for cycles 6..8: no grants, pointer frozen, results still drain
      for (int c = 0; c < 20; c++) begin
         en = !(c >= 6 && c <= 8);
         bus.req_valid = (c <= 10) ? 4'hF : 4'h0;
         #1;
         g = (c < 12) ? grant_tab[c] : -1;
         check($sformatf("en_c%0d_ready", c), bus.req_ready, (g >= 0) ? (1 << g) : 0);
         g = (c >= 8 && c - 8 < 12) ? grant_tab[c-8] : -1;
         check($sformatf("en_c%0d_rsp_valid", c), bus.rsp_valid, (g >= 0) ? (1 << g) : 0);
         if (g >= 0) check($sformatf("en_c%0d_rsp_q", c), bus.rsp_quotient, (g + 1) * 16);
         step();
      end
      en = 1'b1;
      check("en_err", err, 0);

      // reset with 5 divides in flight
      bus.req_valid = 4'hF;
      repeat (5) step();
      check("mid_inflight_5", inflight, 5);
      nrst = 1'b0;
      #1;
      check("mid_rst_ready", bus.req_ready, 0);
      check("mid_rst_din_valid", div_din_valid, 0);
      check("mid_rst_inflight", inflight, 0);
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      step();
      nrst = 1'b1;
      bus.req_valid = '0;
      early = 1'b0;
      repeat (12) begin
         if (bus.rsp_valid != 0) early = 1'b1;
         step();
      end
      check("post_rst_no_rsp", early, 0);
      check("post_rst_err", err, 0);
      bus.req_valid = 4'hF;
      #1;
      check("post_rst_first_grant", bus.req_ready, 4'b0001);
      step();
      bus.req_valid = '0;
      repeat (10) step();

      // error flags
      set_req(0, 8'h80, 8'h40);
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      check("err_range", err, 2'b10);
      repeat (9) step();
      check("err_range_drain", err, 2'b10);
      inject = 1'b1;
      #1;
      check("spurious_no_rsp", bus.rsp_valid, 0);
      step();
      inject = 1'b0;
      check("err_mismatch", err, 2'b11);
      repeat (3) step();
      check("err_sticky", err, 2'b11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fixed_div_arb.md
Name: fixed_div_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined long-division unit (fixed_div_nb, latency STEPS cycles, no backpressure, no tag) among NREQ requesters, e.g. parallel quantiser lanes of the JPEG encoder.
- Accepts requests with valid/ready, issues at most one divide per cycle, and carries a requester tag alongside the divider pipeline.
- Routes each quotient back to its originator.
- Substitutes a saturated result for divide-by-zero and flags protocol errors.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 8, operand width of the shared divider.
- STEPS, 8, quotient width and divider latency in cycles.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  issue enable; 0 blocks new grants, in-flight results still drain
- req_valid  in  NREQ  per-requester request valid
- req_dividend  in  NREQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
- req_divisor  in  NREQ*WIDTH  packed divisors, same packing
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- div_dividend  out  WIDTH  to divider
- div_divisor  out  WIDTH  to divider
- div_din_valid  out  1  to divider
- div_quotient  in  STEPS  from divider
- div_dout_valid  in  1  from divider
- rsp_valid  out  NREQ  one-cycle pulse, at most one bit set
- rsp_quotient  out  STEPS  result, valid when any rsp_valid bit is set
- rsp_dbz  out  1  result came from a zero divisor
- inflight  out  $clog2(STEPS+1)  number of divides in flight
- err  out  2  sticky; [0] tag/divider valid mismatch, [1] operand range violation

Behaviour:
- Reset: all outputs 0; rr pointer = 0; tag pipeline cleared; err cleared. Reset mid-operation discards all in-flight tags. No rsp_valid may follow reset for pre-reset issues.
- Arbitration is combinational. grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ. req_ready = onehot(grant) when en is 1 and some request is valid, else 0.
- req_ready may depend on req_valid. Requesters must hold valid and data stable until accepted.
- Pointer update: on a grant, ptr <= grant+1 (wrapping NREQ-1 -> 0). Otherwise ptr holds.
- Issue is combinational passthrough in the grant cycle: div_din_valid = |req_ready; div_dividend/div_divisor = muxed operands of the granted requester (0 when no grant).
- Tag pipeline: STEPS-deep shift register of {v, idx[$clog2(NREQ)-1:0], dbz}. Advances every cycle. Stage 0 loads {div_din_valid, grant, divisor==0}.
- Result at stage STEPS-1 output: when tag.v is 1, rsp_valid[idx] = 1 and rsp_quotient = dbz ? all-ones : div_quotient. rsp_dbz = dbz.
- Responses are registered-free: they appear the same cycle div_dout_valid is seen, exactly STEPS cycles after issue, in issue order. There is no output backpressure.
- Mismatch: tag.v != div_dout_valid sets err[0]. The response still follows tag.v.
- Range: the divider is correct only for operands < 2^(WIDTH-1). An accepted operand with MSB set sets err[1]. The request is still issued.
- inflight counter: +1 on issue, -1 on response, both in the same cycle = no change. Maximum is STEPS, so the counter never wraps.
- Quotient semantics (divider-defined): q = floor(dividend*2^(STEPS-1)/divisor) for dividend < 2*divisor.

Decomposition:
- Package fixed_div_pkg:
  - tag_t struct {v, idx, dbz}.
  - IDX_W = $clog2(NREQ) helper function.
  - Function rr_pick(valid, ptr) returning the index and a found flag.
- One natural sub-module, rr_arbiter (NREQ-wide round-robin, combinational pick plus registered pointer), reused by later shared-resource blocks.
- Tag shift register stays inline.

Test Plan:
- Single request, dividend=3, divisor=4, on req 2 -> req_ready=0100 in the same cycle; rsp_valid=0100, rsp_quotient=0x60, rsp_dbz=0 exactly 8 cycles later; inflight 1 for 8 cycles.
- All four requesters valid continuously, en=1 -> grants 0,1,2,3,0,... one per cycle; responses back-to-back in the same order 8 cycles later; inflight saturates at 8.
- Divisor=0, dividend=5 on req 1 -> rsp_valid=0010, rsp_quotient=0xFF, rsp_dbz=1; err stays 0.
- en dropped for 3 cycles while reqs are valid -> no grants and ptr frozen; earlier results still emerge; on en=1 arbitration resumes from the saved ptr.
- nrst pulsed with 5 divides in flight -> all outputs 0 and no rsp_valid afterwards; a new request after reset is granted to req 0 first.
- Inject a spurious div_dout_valid with an empty tag pipeline -> err[0]=1 sticky. Dividend=0x80 -> err[1]=1.
